// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART core: bus addresses, status layout,
// oversampling parameters and the FSM state encoding used by both TX and RX.
package spart_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DBL    = 2'b10;
   localparam logic [1:0] ADDR_DBH    = 2'b11;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);

   localparam int unsigned ST_RDA  = 0;
   localparam int unsigned ST_TBR  = 1;
   localparam int unsigned ST_FERR = 2;
   localparam int unsigned ST_OVR  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } fsm_state_t;

endpackage

// File: rtl/spart_if.sv
// Driver-side control signals of the SPART register bus; the 8-bit tri-state
// databus travels as a separate inout port next to this interface.
interface spart_if;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iorw, output ioaddr, input rda, input tbr);
   modport slave  (input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_baud_gen.sv
// Programmable baud generator: 16-bit divisor registers and a down-counter that
// emits a one-cycle tick every divisor+1 clocks, restarting on divisor writes.
module spart_baud_gen
   import spart_pkg::*;
#(
   parameter logic [15:0] DIV_DEFAULT = 16'd651
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [7:0]  i_wdata,
   output logic [15:0] o_divisor,
   output logic        o_tick
);

   logic [15:0] r_div;
   logic [15:0] r_cnt;

   // Counter reloads with the divisor value as it will be after this write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= DIV_DEFAULT;
         r_cnt <= DIV_DEFAULT;
      end else if (i_wr_lo) begin
         r_div[7:0] <= i_wdata;
         r_cnt      <= {r_div[15:8], i_wdata};
      end else if (i_wr_hi) begin
         r_div[15:8] <= i_wdata;
         r_cnt       <= {i_wdata, r_div[7:0]};
      end else if (r_cnt == '0) begin
         r_cnt <= r_div;
      end else begin
         r_cnt <= r_cnt - 16'd1;
      end
   end

   assign o_divisor = r_div;
   assign o_tick    = (r_cnt == '0);

endmodule

// File: rtl/spart_core.sv
// SPART core: 8N1 transmitter and receiver sharing one 16x oversampling baud
// tick, with a 2-bit addressed register bus and tri-state databus.
module spart_core
   import spart_pkg::*;
#(
   parameter logic [15:0] DIV_DEFAULT = 16'd651
) (
   input  logic       clk,
   input  logic       rst,
   spart_if.slave     bus,
   inout  wire  [7:0] databus,
   output logic       txd,
   input  logic       rxd
);

   logic        w_tick;
   logic [15:0] w_divisor;
   logic [7:0]  w_bus_wdata;
   logic        w_wr, w_rd_data, w_rd_stat, w_tx_load, w_tbr;
   logic [7:0]  w_status, w_rdata;

   fsm_state_t        r_tx_state, w_tx_state_nxt;
   logic [7:0]        r_tx_shift, w_tx_shift_nxt;
   logic [2:0]        r_tx_bit,   w_tx_bit_nxt;
   logic [TICK_W-1:0] r_tx_tick,  w_tx_tick_nxt;
   logic              r_txd,      w_txd_nxt;

   fsm_state_t        r_rx_state, w_rx_state_nxt;
   logic [7:0]        r_rx_shift, w_rx_shift_nxt;
   logic [2:0]        r_rx_bit,   w_rx_bit_nxt;
   logic [TICK_W-1:0] r_rx_tick,  w_rx_tick_nxt;
   logic              w_rx_done,  w_rx_ferr;
   logic              r_rx_s1, r_rx_s2;
   logic [7:0]        r_rx_buf;
   logic              r_rda, r_ferr, r_ovr;

   assign w_bus_wdata = databus;
   assign w_wr        = ~bus.iorw;
   assign w_rd_data   = bus.iorw & (bus.ioaddr == ADDR_DATA);
   assign w_rd_stat   = bus.iorw & (bus.ioaddr == ADDR_STATUS);
   assign w_tbr       = (r_tx_state == IDLE);
   assign w_tx_load   = w_wr & (bus.ioaddr == ADDR_DATA) & w_tbr;

   spart_baud_gen #(.DIV_DEFAULT(DIV_DEFAULT)) u_baud (
      .clk       (clk),
      .rst       (rst),
      .i_wr_lo   (w_wr & (bus.ioaddr == ADDR_DBL)),
      .i_wr_hi   (w_wr & (bus.ioaddr == ADDR_DBH)),
      .i_wdata   (w_bus_wdata),
      .o_divisor (w_divisor),
      .o_tick    (w_tick)
   );

   always_comb begin
      w_status           = '0;
      w_status[ST_RDA]   = r_rda;
      w_status[ST_TBR]   = w_tbr;
      w_status[ST_FERR]  = r_ferr;
      w_status[ST_OVR]   = r_ovr;
      case (bus.ioaddr)
         ADDR_DATA:   w_rdata = r_rx_buf;
         ADDR_STATUS: w_rdata = w_status;
         ADDR_DBL:    w_rdata = w_divisor[7:0];
         default:     w_rdata = w_divisor[15:8];
      endcase
   end

   assign databus = bus.iorw ? w_rdata : 8'bz;
   assign bus.rda = r_rda;
   assign bus.tbr = w_tbr;
   assign txd     = r_txd;

   // ---------------- transmitter ----------------
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_tick_nxt  = r_tx_tick;
      if (r_tx_state == IDLE) begin
         if (w_tx_load) begin
            w_tx_state_nxt = START;
            w_tx_shift_nxt = w_bus_wdata;
            w_tx_bit_nxt   = '0;
            w_tx_tick_nxt  = '0;
         end
      end else if (w_tick) begin
         w_tx_tick_nxt = r_tx_tick + 1'b1;
         if (r_tx_tick == TICK_LAST) begin
            case (r_tx_state)
               START: w_tx_state_nxt = DATA;
               DATA: begin
                  w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                  w_tx_bit_nxt   = r_tx_bit + 1'b1;
                  if (r_tx_bit == 3'd7) w_tx_state_nxt = STOP;
               end
               default: w_tx_state_nxt = IDLE;
            endcase
         end
      end
      // txd is registered alongside the state so it never glitches.
      case (w_tx_state_nxt)
         START:   w_txd_nxt = 1'b0;
         DATA:    w_txd_nxt = w_tx_shift_nxt[0];
         default: w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_state <= IDLE;
         r_tx_shift <= '0;
         r_tx_bit   <= '0;
         r_tx_tick  <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx_tick  <= w_tx_tick_nxt;
         r_txd      <= w_txd_nxt;
      end
   end

   // ---------------- receiver ----------------
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_tick_nxt  = r_rx_tick;
      w_rx_done      = 1'b0;
      w_rx_ferr      = 1'b0;
      if (w_tick) begin
         w_rx_tick_nxt = r_rx_tick + 1'b1;
         case (r_rx_state)
            IDLE: begin
               w_rx_tick_nxt = '0;
               if (!r_rx_s2) w_rx_state_nxt = START;
            end
            // Half a bit after the falling edge: confirm the start bit is real.
            START: begin
               if (r_rx_tick == TICK_MID) begin
                  w_rx_tick_nxt  = '0;
                  w_rx_bit_nxt   = '0;
                  w_rx_state_nxt = r_rx_s2 ? IDLE : DATA;
               end
            end
            DATA: begin
               if (r_rx_tick == TICK_LAST) begin
                  w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
                  w_rx_bit_nxt   = r_rx_bit + 1'b1;
                  if (r_rx_bit == 3'd7) w_rx_state_nxt = STOP;
               end
            end
            default: begin
               if (r_rx_tick == TICK_LAST) begin
                  w_rx_state_nxt = IDLE;
                  w_rx_done      = r_rx_s2;
                  w_rx_ferr      = ~r_rx_s2;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_state <= IDLE;
         r_rx_shift <= '0;
         r_rx_bit   <= '0;
         r_rx_tick  <= '0;
      end else begin
         r_rx_s1    <= rxd;
         r_rx_s2    <= r_rx_s1;
         r_rx_state <= w_rx_state_nxt;
         r_rx_shift <= w_rx_shift_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_tick  <= w_rx_tick_nxt;
      end
   end

   // A completing byte beats a same-cycle data read, so nothing is lost or flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_buf <= '0;
         r_rda    <= 1'b0;
         r_ferr   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         if (w_rx_done) r_rx_buf <= r_rx_shift;
         if (w_rx_done)      r_rda <= 1'b1;
         else if (w_rd_data) r_rda <= 1'b0;
         if (w_rx_ferr)      r_ferr <= 1'b1;
         else if (w_rd_stat) r_ferr <= 1'b0;
         if (w_rx_done && r_rda && !w_rd_data) r_ovr <= 1'b1;
         else if (w_rd_stat)                   r_ovr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spart_core.sv
// Directed self-checking bench for spart_core: register access, TX framing,
// RX reception, false start, framing error, overrun and asynchronous reset.
module tb_spart_core;
   import spart_pkg::*;

   localparam int BIT_CLK = 64;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic       txd;
   logic [7:0] tb_wdata;
   wire  [7:0] databus;
   int         n_cmp;
   int         n_err;

   spart_if bus ();

   assign databus = bus.iorw ? 8'bz : tb_wdata;

   spart_core #(.DIV_DEFAULT(16'd651)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .databus (databus),
      .txd     (txd),
      .rxd     (rxd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic bus_idle();
      bus.iorw   = 1'b1;
      bus.ioaddr = ADDR_DBH;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.iorw   = 1'b0;
      bus.ioaddr = a;
      tb_wdata   = d;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.iorw   = 1'b1;
      bus.ioaddr = a;
      #1 d = databus;
      @(negedge clk);
      bus_idle();
   endtask

   // Sends one 8N1 frame on rxd at 64 clk/bit after restarting the baud phase;
   // optionally issues a data read at loop index rd_at and records when rda rose.
   task automatic rx_frame(input logic [7:0] d, input logic stop, input int rd_at,
                           output int rise, output logic [7:0] rd_val);
      logic [9:0] frm;
      frm    = {stop, d, 1'b0};
      rise   = -1;
      rd_val = 8'h00;
      @(negedge clk);
      bus.iorw   = 1'b0;
      bus.ioaddr = ADDR_DBL;
      tb_wdata   = 8'd3;
      for (int i = 0; i < 10 * BIT_CLK; i++) begin
         @(negedge clk);
         if (rise < 0 && bus.rda === 1'b1) rise = i;
         rxd = frm[i / BIT_CLK];
         if (i == rd_at) begin
            bus.iorw   = 1'b1;
            bus.ioaddr = ADDR_DATA;
            #1 rd_val = databus;
         end else begin
            bus_idle();
         end
      end
      @(negedge clk);
      rxd = 1'b1;
      bus_idle();
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1;
      rxd = 1'b1;
      tb_wdata = 8'h00;
      bus_idle();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", txd); end
      n_cmp++; if (bus.tbr !== 1'b1) begin n_err++; $display("FAIL reset_tbr: got %b want 1", bus.tbr); end
      n_cmp++; if (bus.rda !== 1'b0) begin n_err++; $display("FAIL reset_rda: got %b want 0", bus.rda); end
      bus_read(ADDR_STATUS, v);
      n_cmp++; if (v !== 8'h02) begin n_err++; $display("FAIL reset_status: got %h want 02", v); end
      bus_read(ADDR_DBL, v);
      n_cmp++; if (v !== 8'h8B) begin n_err++; $display("FAIL reset_dbl: got %h want 8b", v); end
      bus_read(ADDR_DBH, v);
      n_cmp++; if (v !== 8'h02) begin n_err++; $display("FAIL reset_dbh: got %h want 02", v); end
      bus_read(ADDR_DATA, v);
      n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_rxbuf: got %h want 00", v); end
   endtask

   task automatic test_divisor();
      logic [7:0] v;
      bus_write(ADDR_DBL, 8'h34);
      bus_write(ADDR_DBH, 8'h12);
      bus_write(ADDR_STATUS, 8'hFF);
      bus_read(ADDR_DBL, v);
      n_cmp++; if (v !== 8'h34) begin n_err++; $display("FAIL div_lo: got %h want 34", v); end
      bus_read(ADDR_DBH, v);
      n_cmp++; if (v !== 8'h12) begin n_err++; $display("FAIL div_hi: got %h want 12", v); end
      bus_read(ADDR_STATUS, v);
      n_cmp++; if (v !== 8'h02) begin n_err++; $display("FAIL status_write_ignored: got %h want 02", v); end
   endtask

   // Divisor 0: every txd level lasts exactly 16 clk; a write while busy is dropped.
   task automatic test_tx_frame(input logic [7:0] d);
      logic [9:0] seq;
      seq = {1'b1, d, 1'b0};
      bus_write(ADDR_DBL, 8'h00);
      bus_write(ADDR_DBH, 8'h00);
      @(negedge clk);
      bus.iorw   = 1'b0;
      bus.ioaddr = ADDR_DATA;
      tb_wdata   = d;
      for (int k = 0; k < 160; k++) begin
         @(negedge clk);
         if (k == 40) begin
            bus.iorw   = 1'b0;
            bus.ioaddr = ADDR_DATA;
            tb_wdata   = 8'hFF;
         end else begin
            bus_idle();
         end
         #1;
         if (k == 0) begin
            n_cmp++; if (bus.tbr !== 1'b0) begin n_err++; $display("FAIL tx_tbr_busy: got %b want 0", bus.tbr); end
         end
         n_cmp++;
         if (txd !== seq[k / 16]) begin
            n_err++; $display("FAIL tx_bit[%0d] data %h: got %b want %b", k, d, txd, seq[k / 16]);
         end
      end
      n_cmp++; if (bus.tbr !== 1'b0) begin n_err++; $display("FAIL tx_tbr_at_160: got %b want 0", bus.tbr); end
      @(negedge clk);
      n_cmp++; if (bus.tbr !== 1'b1) begin n_err++; $display("FAIL tx_tbr_done: got %b want 1", bus.tbr); end
      n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL tx_idle_txd: got %b want 1", txd); end
   endtask

   task automatic test_tx_reset();
      bus_write(ADDR_DBL, 8'h00);
      bus_write(ADDR_DBH, 8'h00);
      @(negedge clk);
      bus.iorw   = 1'b0;
      bus.ioaddr = ADDR_DATA;
      tb_wdata   = 8'hC3;
      for (int k = 0; k < 72; k++) begin
         @(negedge clk);
         bus_idle();
      end
      n_cmp++; if (txd !== 1'b0) begin n_err++; $display("FAIL txrst_pre_txd: got %b want 0", txd); end
      bus.ioaddr = ADDR_DBL;
      rst = 1'b1;
      #1;
      n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL txrst_txd: got %b want 1", txd); end
      n_cmp++; if (bus.tbr !== 1'b1) begin n_err++; $display("FAIL txrst_tbr: got %b want 1", bus.tbr); end
      n_cmp++; if (databus !== 8'h8B) begin n_err++; $display("FAIL txrst_dbl: got %h want 8b", databus); end
      bus.ioaddr = ADDR_DBH;
      #1;
      n_cmp++; if (databus !== 8'h02) begin n_err++; $display("FAIL txrst_dbh: got %h want 02", databus); end
      @(negedge clk);
      rst = 1'b0;
      bus_idle();
      test_tx_frame(8'h5A);
   endtask

   task automatic test_rx();
      int rise;
      logic [7:0] v;
      rx_frame(8'h3C, 1'b1, -1, rise, v);
      n_cmp++;
      if (rise < 592 || rise > 639) begin n_err++; $display("FAIL rx_rda_timing: got %0d want 592..639", rise); end
      n_cmp++; if (bus.rda !== 1'b1) begin n_err++; $display("FAIL rx_rda: got %b want 1", bus.rda); end
      bus_read(ADDR_DATA, v);
      n_cmp++; if (v !== 8'h3C) begin n_err++; $display("FAIL rx_data: got %h want 3c", v); end
      n_cmp++; if (bus.rda !== 1'b0) begin n_err++; $display("FAIL rx_rda_clear: got %b want 0", bus.rda); end
   endtask

   task automatic test_false_start();
      logic [7:0] v;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         rxd = (i >= 20);
      end
      n_cmp++; if (bus.rda !== 1'b0) begin n_err++; $display("FAIL fstart_rda: got %b want 0", bus.rda); end
      bus_read(ADDR_STATUS, v);
      n_cmp++; if (v !== 8'h02) begin n_err++; $display("FAIL fstart_status: got %h want 02", v); end
   endtask

   task automatic test_frame_error();
      int rise;
      logic [7:0] v;
      rx_frame(8'h55, 1'b0, -1, rise, v);
      repeat (100) @(negedge clk);
      n_cmp++; if (bus.rda !== 1'b0) begin n_err++; $display("FAIL ferr_rda: got %b want 0", bus.rda); end
      bus_read(ADDR_STATUS, v);
      n_cmp++; if (v !== 8'h06) begin n_err++; $display("FAIL ferr_status: got %h want 06", v); end
      bus_read(ADDR_STATUS, v);
      n_cmp++; if (v !== 8'h02) begin n_err++; $display("FAIL ferr_status_clear: got %h want 02", v); end
   endtask

   task automatic test_overrun();
      int rise;
      logic [7:0] v;
      rx_frame(8'h11, 1'b1, -1, rise, v);
      rx_frame(8'h22, 1'b1, -1, rise, v);
      n_cmp++; if (bus.rda !== 1'b1) begin n_err++; $display("FAIL ovr_rda: got %b want 1", bus.rda); end
      bus_read(ADDR_STATUS, v);
      n_cmp++; if (v !== 8'h0B) begin n_err++; $display("FAIL ovr_status: got %h want 0b", v); end
      bus_read(ADDR_DATA, v);
      n_cmp++; if (v !== 8'h22) begin n_err++; $display("FAIL ovr_data: got %h want 22", v); end
      bus_read(ADDR_STATUS, v);
      n_cmp++; if (v !== 8'h02) begin n_err++; $display("FAIL ovr_status_clear: got %h want 02", v); end
   endtask

   // Frame 0x33 measures when a byte completes; frame 0x44 repeats the same
   // timing with a data read placed on exactly that completion cycle.
   task automatic test_back_to_back();
      int rise_a;
      int rise_b;
      logic [7:0] v;
      rx_frame(8'h33, 1'b1, -1, rise_a, v);
      n_cmp++;
      if (rise_a < 592 || rise_a > 639) begin n_err++; $display("FAIL b2b_rda_timing: got %0d want 592..639", rise_a); end
      rx_frame(8'h44, 1'b1, rise_a - 1, rise_b, v);
      n_cmp++; if (v !== 8'h33) begin n_err++; $display("FAIL b2b_read_old: got %h want 33", v); end
      n_cmp++; if (bus.rda !== 1'b1) begin n_err++; $display("FAIL b2b_rda: got %b want 1", bus.rda); end
      bus_read(ADDR_STATUS, v);
      n_cmp++; if (v !== 8'h03) begin n_err++; $display("FAIL b2b_status: got %h want 03", v); end
      bus_read(ADDR_DATA, v);
      n_cmp++; if (v !== 8'h44) begin n_err++; $display("FAIL b2b_data: got %h want 44", v); end
      n_cmp++; if (bus.rda !== 1'b0) begin n_err++; $display("FAIL b2b_rda_clear: got %b want 0", bus.rda); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_divisor();
      test_tx_frame(8'hA5);
      test_tx_reset();
      test_rx();
      test_false_start();
      test_frame_error();
      test_overrun();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spart_core.md
Name: spart_core

Overview:
- Special-purpose asynchronous receiver/transmitter: 8N1 serial TX/RX with a programmable baud generator.
- Sits directly downstream of the SPART driver. It exposes an 8-bit tri-state databus with a 2-bit register address and read/write strobe.
- Reports receive-data-available (rda) and transmit-buffer-ready (tbr) so the driver can pace traffic.
- Drives the board txd pin and samples the rxd pin.

Parameters:
- DIV_DEFAULT, 16'd651: reset value of the baud divisor, in clk cycles per oversample tick (100 MHz / (16 × 9600)).
- OVERSAMPLE, 16: ticks per serial bit. Fixed; only 16 is supported.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- iorw  input  1  1 = bus read (core drives databus), 0 = bus write (core samples databus)
- ioaddr  input  2  00 data (RX read / TX write), 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  bidirectional data; core drives only while iorw=1, otherwise hi-Z
- rda  output  1  received byte waiting in the RX buffer
- tbr  output  1  transmitter idle; a TX write is accepted
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous to clk

Behaviour:
- Reset values: txd=1, tbr=1, rda=0, divisor=DIV_DEFAULT, RX buffer=0, ferr=0, ovr=0, both FSMs in IDLE.
- Bus access: every access is single-cycle and takes effect at the posedge where it is presented.
- Read mux (combinational while iorw=1):
  - ioaddr 00: RX buffer
  - ioaddr 01: {4'b0, ovr, ferr, tbr, rda}
  - ioaddr 10: divisor[7:0]
  - ioaddr 11: divisor[15:8]
- Read side effects:
  - A read of 00 clears rda at the next edge.
  - A read of 01 clears ovr and ferr at the next edge.
  - Reads of 10 and 11 have no side effects; idle polling at 11 is harmless.
- Writes:
  - Write 00 with tbr=1: loads the TX shift register; tbr=0 from the next cycle.
  - Write 00 with tbr=0: ignored, no corruption.
  - Write 10 or 11: updates that divisor byte and reloads the baud counter.
  - Write 01: ignored.
- Baud generator:
  - 16-bit down-counter; tick pulses one cycle when the count reaches 0, then reloads the divisor.
  - Tick period is divisor+1 clk. A divisor of 0 gives a tick every cycle.
- TX FSM, IDLE → START → DATA → STOP → IDLE:
  - Each bit lasts 16 ticks; data goes out LSB first.
  - tbr returns to 1 in the cycle after the last stop-bit tick.
- RX front end: rxd passes through a 2-flop synchronizer before use.
- RX FSM, IDLE → START → DATA → STOP → IDLE:
  - IDLE: a low on synchronized rxd at a tick enters START.
  - START: at the 8th tick rxd is rechecked. If high, this is a false start: return to IDLE, no flags set.
  - DATA: sample every 16th tick thereafter, so bits are sampled mid-bit; 8 bits LSB first.
  - STOP, sampled 1: the RX buffer loads and rda=1 on the next cycle.
  - STOP, sampled 0: ferr=1, the byte is discarded, rda is unchanged.
- Overrun: a byte completes while rda=1 and is not being cleared that cycle → buffer overwritten, ovr=1.
- Simultaneous data read and byte completion in the same cycle: rda stays 1 with the new byte, ovr not set.
- TX and RX run independently; full duplex is required.
- rst asserted mid-frame:
  - txd returns to 1 immediately (asynchronous); a partial frame is abandoned.
  - RX returns to IDLE.

Decomposition:
- spart_pkg holds:
  - address constants ADDR_DATA, ADDR_STATUS, ADDR_DBL, ADDR_DBH
  - the shared 2-bit FSM state enum {IDLE, START, DATA, STOP}
  - OVERSAMPLE = 16
  - the status bit-position constants
- One sub-module, spart_baud_gen: divisor registers, down-counter, tick output, reload-on-write.
- TX and RX FSMs stay in spart_core.

Test Plan:
- Write 0x00 to 10 and 0x00 to 11 (divisor 0); write 0xA5 to 00 → tbr=0 next cycle; txd = 0,1,0,1,0,0,1,0,1,1, each level held 16 clk; tbr=1 after 160 clk.
- Divisor 3, drive rxd frame 0x3C (64 clk/bit) → rda=1 after stop mid-sample; read 00 returns 0x3C; rda=0 next cycle.
- Divisor 3, rxd low for 20 clk, then high → no rda, status read 0x02 (tbr only), RX back in IDLE.
- Frame 0x55 with stop bit 0 → rda stays 0, status 0x06; a second status read returns 0x02.
- Two frames 0x11 then 0x22 with no read → rda=1, status 0x0B, read 00 returns 0x22; frame completing in the same cycle as a data read → ovr stays 0.
- Assert rst at the 4th data bit of a TX frame → txd=1, tbr=1, divisor=651 immediately; a new write of 0x5A transmits cleanly.
